bch_byte_packer: RTL

Output stage directly downstream of the Chien-search corrector of the BCH decoder. Takes the corrected bit-serial codeword, counts 16200-bit frames and discards the 192 parity bits. Packs the 16008 information bits MSB-first into 2001 bytes and presents them through a small FIFO with a valid/ready handshake and start-of-frame/end-of-frame markers.

---
 rtl/bch_pkg.sv | 16 +
 rtl/bch_out_fifo.sv | 48 ++++
 rtl/bch_byte_packer.sv | 123 ++++++++++++
 3 files changed

// File: rtl/bch_pkg.sv
// Shared BCH decoder constants and the byte-packer state type.
package bch_pkg;

    localparam int unsigned BCH_N      = 16200;
    localparam int unsigned BCH_K      = 16008;
    localparam int unsigned BCH_PARITY = BCH_N - BCH_K;
    localparam int unsigned BCH_M      = 16;
    localparam int unsigned BCH_T      = 12;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY
    } bch_state_e;

endpackage

// File: rtl/bch_out_fifo.sv
// Synchronous FIFO with combinational read; pointers carry an extra wrap bit.
module bch_out_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 10
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_en_i,
    input  logic [Width-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [Width-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(Depth);

    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic [Width-1:0] mem_q [Depth];
    logic             do_wr, do_rd;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A write into a full FIFO is still accepted when a read frees a slot the same cycle.
    assign do_rd = rd_en_i && !empty_o;
    assign do_wr = wr_en_i && (!full_o || do_rd);

    assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer update.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage write; contents are irrelevant while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end

endmodule

// File: rtl/bch_byte_packer.sv
// Counts codeword bits, packs information bits MSB-first into bytes and drops parity.
module bch_byte_packer
    import bch_pkg::*;
#(
    parameter int unsigned N_BITS     = BCH_N,
    parameter int unsigned K_BITS     = BCH_K,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        bit_in,
    input  logic        bit_valid,
    input  logic        frame_start,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sof,
    output logic        out_eof,
    output logic        overflow,
    output logic        sync_err,
    output logic [15:0] frame_cnt
);

    localparam int unsigned CW       = $clog2(N_BITS);
    localparam int unsigned LastByte = K_BITS / 8 - 1;

    if (((K_BITS % 8) != 0) || (K_BITS >= N_BITS)) begin : g_bad_k
        $error("K_BITS must be a multiple of 8 and smaller than N_BITS");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two, at least 2");
    end

    bch_state_e    state_q;
    logic [CW-1:0] bit_cnt_q;
    logic [CW-1:0] byte_idx;
    logic [6:0]    shreg_q;
    logic          push_q;
    logic [9:0]    push_data_q;   // {sof, eof, data}
    logic          overflow_q;
    logic          sync_err_q;
    logic [15:0]   frame_cnt_q;

    logic [9:0]    fifo_rd;
    logic          fifo_full, fifo_empty, pop;

    assign byte_idx = bit_cnt_q >> 3;
    assign pop      = out_valid && out_ready;

    // Frame FSM: bit counting, byte packing, sticky flags and frame counter.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            overflow_q  <= 1'b0;
            sync_err_q  <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            push_q <= 1'b0;
            if (push_q && fifo_full && !pop) overflow_q <= 1'b1;
            if (bit_valid) begin
                if (frame_start) begin
                    // New bit 0; any unfinished frame is abandoned without an eof.
                    if (state_q != IDLE) sync_err_q <= 1'b1;
                    shreg_q   <= {6'b0, bit_in};
                    bit_cnt_q <= CW'(1);
                    state_q   <= DATA;
                end else begin
                    unique case (state_q)
                        IDLE: ;
                        DATA: begin
                            shreg_q   <= {shreg_q[5:0], bit_in};
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                            if (bit_cnt_q[2:0] == 3'd7) begin
                                push_q      <= 1'b1;
                                push_data_q <= {byte_idx == '0, byte_idx == CW'(LastByte),
                                                shreg_q, bit_in};
                            end
                            if (bit_cnt_q == CW'(K_BITS - 1)) state_q <= PARITY;
                        end
                        PARITY: begin
                            if (bit_cnt_q == CW'(N_BITS - 1)) begin
                                bit_cnt_q   <= '0;
                                frame_cnt_q <= frame_cnt_q + 16'd1;
                                state_q     <= IDLE;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 1'b1;
                            end
                        end
                        default: state_q <= IDLE;
                    endcase
                end
            end
        end
    end

    bch_out_fifo #(
        .Depth (FIFO_DEPTH),
        .Width (10)
    ) u_fifo (
        .clk_i     (CLK),
        .rst_i     (reset),
        .wr_en_i   (push_q),
        .wr_data_i (push_data_q),
        .rd_en_i   (pop),
        .rd_data_o (fifo_rd),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty)
    );

    // Gate the read port so outputs read 0 whenever nothing is presented.
    assign out_valid = !fifo_empty;
    assign out_data  = out_valid ? fifo_rd[7:0] : 8'h00;
    assign out_eof   = out_valid && fifo_rd[8];
    assign out_sof   = out_valid && fifo_rd[9];
    assign overflow  = overflow_q;
    assign sync_err  = sync_err_q;
    assign frame_cnt = frame_cnt_q;

endmodule
